// File: rtl/accum_driver.sv
// accum_driver: initiator for an accumulator's four-phase en/done add handshake.
// Issues an arithmetic operand sequence (base, base+stride, ...), tracks the
// expected accumulator value and compares it with the accumulator at the end.
module accum_driver #(
   parameter int unsigned ACCUM_WIDTH = 64,
   parameter int unsigned ADD_WIDTH   = 32,
   parameter int unsigned CNT_WIDTH   = 16,
   parameter int unsigned TIMEOUT     = 255
) (
   input  logic                   i_clk,
   input  logic                   i_reset,
   input  logic                   i_cmd_valid,
   output logic                   o_cmd_ready,
   input  logic [CNT_WIDTH-1:0]   i_cmd_count,
   input  logic [ADD_WIDTH-1:0]   i_cmd_base,
   input  logic [ADD_WIDTH-1:0]   i_cmd_stride,
   output logic                   o_en,
   output logic [ADD_WIDTH-1:0]   o_add,
   input  logic                   i_done,
   input  logic [ACCUM_WIDTH-1:0] i_accum,
   output logic                   o_busy,
   output logic                   o_seq_done,
   output logic                   o_seq_ok,
   output logic                   o_err_timeout,
   output logic [CNT_WIDTH-1:0]   o_issued,
   output logic [ACCUM_WIDTH-1:0] o_expected
);

   // Wait counter only needs to reach TIMEOUT-1 before the abort fires.
   localparam int unsigned TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ARM     = 3'd1,
      S_ASSERT  = 3'd2,
      S_RELEASE = 3'd3,
      S_CHECK   = 3'd4
   } state_t;

   state_t                 r_state;
   state_t                 w_state_nxt;

   logic [TMO_W-1:0]       r_tmo_cnt;
   logic [CNT_WIDTH-1:0]   r_count;
   logic [ADD_WIDTH-1:0]   r_stride;
   logic [ADD_WIDTH-1:0]   r_operand;
   logic [ACCUM_WIDTH-1:0] r_expected;
   logic [CNT_WIDTH-1:0]   r_issued;

   logic                   r_en;
   logic                   r_cmd_ready;
   logic                   r_busy;
   logic                   r_seq_done;
   logic                   r_seq_ok;
   logic                   r_err_timeout;

   logic                   w_en_nxt;
   logic                   w_cmd_ready_nxt;
   logic                   w_busy_nxt;
   logic                   w_seq_done_nxt;
   logic                   w_seq_ok_nxt;
   logic                   w_err_timeout_nxt;

   logic                   w_accept;
   logic                   w_ack;
   logic                   w_wait;
   logic                   w_progress;
   logic                   w_tmo_hit;
   logic                   w_abort;

   assign w_accept   = (r_state == S_IDLE) && i_cmd_valid;
   assign w_ack      = (r_state == S_ASSERT) && i_done;
   assign w_wait     = (r_state == S_ARM) || (r_state == S_ASSERT) || (r_state == S_RELEASE);
   // ASSERT waits for done=1; ARM and RELEASE wait for done=0.
   assign w_progress = (r_state == S_ASSERT) ? i_done : !i_done;
   assign w_tmo_hit  = w_wait && (r_tmo_cnt == TMO_W'(TIMEOUT - 1));
   // A handshake completing on the last allowed cycle still wins over the abort.
   assign w_abort    = w_tmo_hit && !w_progress;

   // State register.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic.
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         S_IDLE: begin
            if (i_cmd_valid) w_state_nxt = S_ARM;
         end
         S_ARM: begin
            if (!i_done)      w_state_nxt = (r_count == '0) ? S_CHECK : S_ASSERT;
            else if (w_abort) w_state_nxt = S_IDLE;
         end
         S_ASSERT: begin
            if (i_done)       w_state_nxt = S_RELEASE;
            else if (w_abort) w_state_nxt = S_IDLE;
         end
         S_RELEASE: begin
            if (!i_done)      w_state_nxt = (r_issued == r_count) ? S_CHECK : S_ASSERT;
            else if (w_abort) w_state_nxt = S_IDLE;
         end
         S_CHECK: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Output logic: next values for the registered handshake and status outputs.
   always_comb begin
      w_en_nxt          = (w_state_nxt == S_ASSERT);
      w_cmd_ready_nxt   = (w_state_nxt == S_IDLE);
      w_busy_nxt        = (w_state_nxt != S_IDLE);
      w_seq_done_nxt    = 1'b0;
      w_seq_ok_nxt      = 1'b0;
      w_err_timeout_nxt = r_err_timeout;
      if (w_accept) begin
         w_err_timeout_nxt = 1'b0;
      end
      if (r_state == S_CHECK) begin
         w_seq_done_nxt = 1'b1;
         w_seq_ok_nxt   = (i_accum == r_expected);
      end
      if (w_abort) begin
         w_seq_done_nxt    = 1'b1;
         w_seq_ok_nxt      = 1'b0;
         w_err_timeout_nxt = 1'b1;
      end
   end

   // Registered outputs.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_en          <= 1'b0;
         r_cmd_ready   <= 1'b1;
         r_busy        <= 1'b0;
         r_seq_done    <= 1'b0;
         r_seq_ok      <= 1'b0;
         r_err_timeout <= 1'b0;
      end else begin
         r_en          <= w_en_nxt;
         r_cmd_ready   <= w_cmd_ready_nxt;
         r_busy        <= w_busy_nxt;
         r_seq_done    <= w_seq_done_nxt;
         r_seq_ok      <= w_seq_ok_nxt;
         r_err_timeout <= w_err_timeout_nxt;
      end
   end

   // Command capture, operand stepping, expected-sum tracking and wait timer.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_tmo_cnt  <= '0;
         r_count    <= '0;
         r_stride   <= '0;
         r_operand  <= '0;
         r_expected <= '0;
         r_issued   <= '0;
      end else begin
         if (w_state_nxt != r_state) begin
            r_tmo_cnt <= '0;
         end else if (w_wait) begin
            r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
         end

         if (w_accept) begin
            r_count    <= i_cmd_count;
            r_stride   <= i_cmd_stride;
            r_operand  <= i_cmd_base;
            r_expected <= i_accum;
            r_issued   <= '0;
         end else if (w_ack) begin
            r_expected <= r_expected + ACCUM_WIDTH'(r_operand);
            r_issued   <= r_issued + CNT_WIDTH'(1);
            r_operand  <= r_operand + r_stride;
         end
      end
   end

   assign o_en          = r_en;
   assign o_add         = r_operand;
   assign o_cmd_ready   = r_cmd_ready;
   assign o_busy        = r_busy;
   assign o_seq_done    = r_seq_done;
   assign o_seq_ok      = r_seq_ok;
   assign o_err_timeout = r_err_timeout;
   assign o_issued      = r_issued;
   assign o_expected    = r_expected;

endmodule

// File: tb/tb_accum_driver.sv
// Bench for accum_driver: reference accumulator, protocol monitor, table vectors,
// randomized commands against an arithmetic model, and timeout/reset sequences.
module tb_accum_driver;

   localparam int unsigned AW  = 64;
   localparam int unsigned DW  = 32;
   localparam int unsigned CW  = 16;
   localparam int unsigned TMO = 8;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [CW-1:0] cmd_count = '0;
   logic [DW-1:0] cmd_base = '0;
   logic [DW-1:0] cmd_stride = '0;
   logic          en;
   logic [DW-1:0] add;
   logic          done;
   logic [AW-1:0] accum;
   logic          busy;
   logic          seq_done;
   logic          seq_ok;
   logic          err_timeout;
   logic [CW-1:0] issued;
   logic [AW-1:0] expected;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   accum_driver #(
      .ACCUM_WIDTH(AW), .ADD_WIDTH(DW), .CNT_WIDTH(CW), .TIMEOUT(TMO)
   ) dut (
      .i_clk(clk), .i_reset(reset),
      .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
      .i_cmd_count(cmd_count), .i_cmd_base(cmd_base), .i_cmd_stride(cmd_stride),
      .o_en(en), .o_add(add), .i_done(done), .i_accum(accum),
      .o_busy(busy), .o_seq_done(seq_done), .o_seq_ok(seq_ok),
      .o_err_timeout(err_timeout), .o_issued(issued), .o_expected(expected)
   );

   // Reference accumulator: one-cycle registered ack. mode 0 normal, 1 adds op+1, 2 done stuck low.
   int            mode = 0;
   logic [AW-1:0] acc_base = '0;
   logic [AW-1:0] acc_sum;
   logic          acc_clr = 1'b0;
   assign accum = acc_base + acc_sum;

   always @(posedge clk) begin
      if (reset || acc_clr) begin
         acc_sum <= '0;
         done    <= 1'b0;
      end else if (mode == 2) begin
         done <= 1'b0;
      end else if (en && !done) begin
         acc_sum <= acc_sum + AW'(add) + ((mode == 1) ? AW'(1) : AW'(0));
         done    <= 1'b1;
      end else if (!en && done) begin
         done <= 1'b0;
      end
   end

   // Protocol monitor: operand log, en-high run lengths, rule violations, seq_done pulses.
   logic          en_q = 1'b0;
   logic          done_q = 1'b0;
   logic [DW-1:0] add_q = '0;
   int            run_len = 0;
   int            runs[$];
   logic [DW-1:0] adds[$];
   int            viol = 0;
   int            pulses = 0;

   always @(negedge clk) begin
      if (reset) begin
         en_q    = 1'b0;
         done_q  = 1'b0;
         run_len = 0;
      end else begin
         if (en && !en_q) begin
            adds.push_back(add);
            if (done_q) viol++;
         end
         if (en && en_q && (add != add_q)) viol++;
         if (en) run_len++;
         else if (en_q) begin
            runs.push_back(run_len);
            run_len = 0;
         end
         if (seq_done) pulses++;
         en_q   = en;
         done_q = done;
         add_q  = add;
      end
   end

   task automatic chk(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Zero the reference accumulator and preload it with acc0.
   task automatic preset_acc(input logic [AW-1:0] acc0);
      acc_base = acc0;
      acc_clr  = 1'b1;
      @(posedge clk);
      #1 acc_clr = 1'b0;
      @(negedge clk);
   endtask

   // Launch a command and wait (bounded) for seq_done; lat counts negedges after accept.
   task automatic run_cmd(input logic [DW-1:0] base, input logic [DW-1:0] stride,
                          input logic [CW-1:0] count, output int lat, output bit seen);
      int n = 0;
      while (!cmd_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("cmd_ready_before_cmd", AW'(cmd_ready), 1);
      adds.delete();
      runs.delete();
      cmd_base   = base;
      cmd_stride = stride;
      cmd_count  = count;
      cmd_valid  = 1'b1;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      lat  = 0;
      seen = 1'b0;
      for (int k = 0; k < 2000; k++) begin
         @(negedge clk);
         lat++;
         if (seq_done) begin
            seen = 1'b1;
            break;
         end
      end
      #1;
      chk("seq_done_seen", AW'(seen), 1);
   endtask

   // Expected sum from the operand rule: acc0 + sum of (base + i*stride) mod 2^DW, mod 2^AW.
   function automatic logic [AW-1:0] ref_sum(input logic [AW-1:0] acc0, input logic [DW-1:0] base,
                                             input logic [DW-1:0] stride, input int count);
      logic [AW-1:0] s = acc0;
      for (int i = 0; i < count; i++) begin
         logic [DW-1:0] op = base + DW'(i) * stride;
         s = s + AW'(op);
      end
      return s;
   endfunction

   // Common checks after a normally completing sequence.
   task automatic chk_seq(input string tag, input logic [DW-1:0] base, input logic [DW-1:0] stride,
                          input int count, input logic [AW-1:0] exp_sum, input bit exp_ok);
      int bad_runs = 0;
      chk({tag, "_seq_ok"}, AW'(seq_ok), AW'(exp_ok));
      chk({tag, "_expected"}, expected, exp_sum);
      chk({tag, "_issued"}, AW'(issued), AW'(count));
      chk({tag, "_err_timeout"}, AW'(err_timeout), 0);
      chk({tag, "_busy"}, AW'(busy), 0);
      chk({tag, "_n_adds"}, AW'(adds.size()), AW'(count));
      for (int i = 0; i < count && i < adds.size(); i++) begin
         logic [DW-1:0] op = base + DW'(i) * stride;
         chk({tag, "_add_order"}, AW'(adds[i]), AW'(op));
      end
      foreach (runs[i]) if (runs[i] != 2) bad_runs++;
      chk({tag, "_en_high_2cyc"}, AW'(bad_runs), 0);
      chk({tag, "_protocol"}, AW'(viol), 0);
   endtask

   typedef struct {
      string         name;
      logic [DW-1:0] base;
      logic [DW-1:0] stride;
      logic [CW-1:0] count;
      logic [AW-1:0] acc0;
      int            mode;
      logic [AW-1:0] exp_sum;
      bit            exp_ok;
   } vec_t;

   vec_t vecs[5];

   initial begin
      int  lat;
      bit  seen;
      int  p0;

      vecs[0] = '{"basic",    32'd5,          32'd3, 16'd4, 64'd0,                  0, 64'h26,               1'b1};
      vecs[1] = '{"opwrap",   32'hFFFF_FFFF,  32'd1, 16'd2, 64'd0,                  0, 64'hFFFF_FFFF,        1'b1};
      vecs[2] = '{"cnt0",     32'd7,          32'd0, 16'd0, 64'h1234,               0, 64'h1234,             1'b1};
      vecs[3] = '{"mismatch", 32'd1,          32'd0, 16'd3, 64'd0,                  1, 64'd3,                1'b0};
      vecs[4] = '{"accwrap",  32'd10,         32'd5, 16'd3, 64'hFFFF_FFFF_FFFF_FFF0, 0, 64'h1D,               1'b1};

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_en", AW'(en), 0);
      chk("rst_add", AW'(add), 0);
      chk("rst_cmd_ready", AW'(cmd_ready), 1);
      chk("rst_busy", AW'(busy), 0);
      chk("rst_seq_done", AW'(seq_done), 0);
      chk("rst_seq_ok", AW'(seq_ok), 0);
      chk("rst_err_timeout", AW'(err_timeout), 0);
      chk("rst_issued", AW'(issued), 0);
      chk("rst_expected", expected, 0);
      reset = 1'b0;
      @(negedge clk);

      // Table-driven vectors
      for (int v = 0; v < 5; v++) begin
         mode = vecs[v].mode;
         preset_acc(vecs[v].acc0);
         run_cmd(vecs[v].base, vecs[v].stride, vecs[v].count, lat, seen);
         chk_seq(vecs[v].name, vecs[v].base, vecs[v].stride, int'(vecs[v].count),
                 vecs[v].exp_sum, vecs[v].exp_ok);
         if (vecs[v].count == 0) chk("cnt0_latency", AW'((lat >= 2) && (lat <= 3)), 1);
         if (v == 3) chk("mismatch_accum", accum, 64'd6);
      end

      // Randomized commands against the arithmetic model
      for (int r = 0; r < 20; r++) begin
         logic [DW-1:0] b = $urandom;
         logic [DW-1:0] s = $urandom;
         int            c = $urandom_range(0, 6);
         logic [AW-1:0] a0 = {$urandom, $urandom};
         bit            p1 = 1'($urandom_range(0, 1));
         mode = p1 ? 1 : 0;
         preset_acc(a0);
         run_cmd(b, s, CW'(c), lat, seen);
         chk_seq("rand", b, s, c, ref_sum(a0, b, s, c), !p1 || (c == 0));
      end

      // Timeout: done never answers, en must drop after TMO cycles
      mode = 2;
      preset_acc(64'd0);
      run_cmd(32'd9, 32'd1, 16'd3, lat, seen);
      chk("tmo_err_timeout", AW'(err_timeout), 1);
      chk("tmo_seq_ok", AW'(seq_ok), 0);
      chk("tmo_issued", AW'(issued), 0);
      chk("tmo_en_low", AW'(en), 0);
      chk("tmo_n_runs", AW'(runs.size()), 1);
      if (runs.size() > 0) chk("tmo_en_high_len", AW'(runs[0]), AW'(TMO));
      @(negedge clk);
      chk("tmo_err_sticky", AW'(err_timeout), 1);

      // A following command clears err_timeout on accept
      mode = 0;
      cmd_base = 32'd2; cmd_stride = 32'd0; cmd_count = 16'd1;
      adds.delete(); runs.delete();
      cmd_valid = 1'b1;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      @(negedge clk);
      chk("tmo_cleared_on_accept", AW'(err_timeout), 0);
      chk("busy_after_accept", AW'(busy), 1);
      chk("cmd_ready_low_busy", AW'(cmd_ready), 0);
      seen = 1'b0;
      for (int k = 0; k < 200 && !seen; k++) begin
         @(negedge clk);
         seen = seq_done;
      end
      #1;
      chk("post_tmo_seq_done", AW'(seen), 1);
      chk("post_tmo_seq_ok", AW'(seq_ok), 1);

      // Reset during the second ASSERT
      preset_acc(64'd0);
      adds.delete(); runs.delete();
      cmd_base = 32'd4; cmd_stride = 32'd1; cmd_count = 16'd4;
      cmd_valid = 1'b1;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 200 && !seen; k++) begin
         @(negedge clk);
         #1;
         seen = (adds.size() >= 2) && en;
      end
      chk("rstmid_reached_assert2", AW'(seen), 1);
      p0 = pulses;
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("rstmid_en", AW'(en), 0);
      chk("rstmid_cmd_ready", AW'(cmd_ready), 1);
      chk("rstmid_busy", AW'(busy), 0);
      chk("rstmid_issued", AW'(issued), 0);
      chk("rstmid_seq_done", AW'(seq_done), 0);
      @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      chk("rstmid_no_pulse", AW'(pulses - p0), 0);
      chk("rstmid_ready_after", AW'(cmd_ready), 1);
      chk("rstmid_en_idle", AW'(en), 0);

      // Recovery after reset
      mode = 0;
      preset_acc(64'd100);
      run_cmd(32'd5, 32'd3, 16'd4, lat, seen);
      chk_seq("recover", 32'd5, 32'd3, 4, 64'd138, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/accum_driver.md
Name: accum_driver

Overview:
- Initiator for the accumulator's four-phase en/done add interface: drives `en`/`add` and waits on `done`.
- Accepts a command describing an arithmetic operand sequence (base, stride, count) and issues each operand as one full handshake.
- Tracks the expected accumulated result and checks it against the accumulator's `accum` output at sequence end.
- Sits between a test/control sequencer and one accumulator instance.

Parameters:
- ACCUM_WIDTH, 64, width of the accumulator value being checked.
- ADD_WIDTH, 32, operand width; must be ≤ ACCUM_WIDTH.
- CNT_WIDTH, 16, width of the operand count.
- TIMEOUT, 255, maximum cycles spent in any wait state before abort; must be ≥ 1.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  high only in IDLE.
- cmd_count  in  CNT_WIDTH  number of operands to issue.
- cmd_base  in  ADD_WIDTH  first operand.
- cmd_stride  in  ADD_WIDTH  increment between operands.
- en  out  1  handshake request to accumulator.
- add  out  ADD_WIDTH  operand; stable while en=1.
- done  in  1  handshake acknowledge from accumulator.
- accum  in  ACCUM_WIDTH  accumulator's current value.
- busy  out  1  high in any state except IDLE.
- seq_done  out  1  one-cycle pulse at end of sequence (pass, fail or abort).
- seq_ok  out  1  valid with seq_done; 1 = accum matched expected.
- err_timeout  out  1  sticky; set on abort, cleared on next command accept.
- issued  out  CNT_WIDTH  operands completed in the current or last sequence.
- expected  out  ACCUM_WIDTH  running expected accumulator value.

Behaviour:
- Reset: sampled at the clock edge while reset=1. State=IDLE, en=0, add=0, seq_done=0, seq_ok=0, err_timeout=0, issued=0, expected=0, timeout counter=0. A reset mid-sequence drops en on that edge; no seq_done is produced.
- States: IDLE, ARM, ASSERT, RELEASE, CHECK.
- IDLE:
  - cmd_ready=1. On cmd_valid&cmd_ready, capture count, base and stride.
  - Load the operand register with base and expected with the current accum. Clear issued, err_timeout and the timeout counter.
  - Go to ARM.
- ARM (en=0):
  - Wait for done=0; this guards against a stale ack.
  - If done=0 and count≠0, go to ASSERT. If done=0 and count=0, go to CHECK.
- ASSERT (en=1, add=operand):
  - On sampling done=1: expected += zero-extended operand (mod 2^ACCUM_WIDTH), issued += 1, operand += stride (mod 2^ADD_WIDTH).
  - Go to RELEASE.
- RELEASE (en=0):
  - On sampling done=0, go to CHECK if issued==count, else to ASSERT.
- CHECK (one cycle):
  - seq_done=1 and seq_ok=(accum==expected) are registered outputs, asserted the cycle after CHECK.
  - Go to IDLE.
- Timeout:
  - The counter resets on every state entry and increments each cycle in ARM, ASSERT and RELEASE.
  - On reaching TIMEOUT: set err_timeout=1, force en=0, pulse seq_done with seq_ok=0, go to IDLE. issued keeps the completed count.
- Handshake rules:
  - en never rises while done=1 is sampled.
  - add changes only while en=0.
  - Against an accumulator with a one-cycle registered ack, each operand takes 4 cycles: en high 2 cycles, low 2 cycles.
- Width rules: operands wrap at ADD_WIDTH; the expected sum wraps at ACCUM_WIDTH. No saturation.
- cmd inputs are ignored outside IDLE. cmd_valid held high re-launches on the first IDLE cycle.

Test Plan:
- Basic sequence: accum starts 0; base=5, stride=3, count=4. Required: adds 5, 8, 11, 14 in order; expected=0x26; seq_done with seq_ok=1; issued=4; each en high-phase exactly 2 cycles with a reference accumulator.
- Operand wrap: base=0xFFFFFFFF, stride=1, count=2. Required: add=0xFFFFFFFF then 0x00000000; expected=0xFFFFFFFF; seq_ok=1.
- Count zero: base=7, count=0. Required: en never asserted; seq_done 2–3 cycles after accept with seq_ok=1; issued=0.
- Timeout: done tied 0, TIMEOUT=8, count=3. Required: en high 8 cycles then 0; err_timeout=1; seq_done with seq_ok=0; issued=0. A following command clears err_timeout.
- Mismatch: accumulator model adds operand+1; base=1, stride=0, count=3. Required: expected=3, accum=6, seq_ok=0, err_timeout=0.
- Reset mid-op: assert reset during the second ASSERT. Required: en=0 and state IDLE the next cycle; no seq_done; cmd_ready=1 after reset deasserts.
